// File: rtl/mul_serial_mac.sv
// mul_serial_mac: bit-serial signed multiply-accumulate stage.
// One operand pair per transaction. a*b is formed MSB-first over WIDTH
// cycles by shift-and-add, with the first step subtracting because a's MSB
// carries negative weight. The product is added into a wrapping accumulator,
// and the accumulator is presented downstream when the transaction is marked
// last.
module mul_serial_mac #(
    parameter  int WIDTH     = 8,
    parameter  int ACC_WIDTH = 32,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                        r_state;
    logic [WIDTH-1:0]              r_a;
    logic [WIDTH-1:0]              r_b;
    logic                          r_first;
    logic                          r_last;
    logic [CNT_W-1:0]              r_cnt;
    logic signed [2*WIDTH-1:0]     r_pp;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic                          r_in_ready;
    logic                          r_out_valid;

    logic [CNT_W-1:0]              w_bit_idx;
    logic                          w_a_bit;
    logic                          w_last_step;
    logic signed [2*WIDTH-1:0]     w_b_ext;
    logic signed [2*WIDTH-1:0]     w_addend;
    logic signed [2*WIDTH-1:0]     w_pp_next;
    logic signed [ACC_WIDTH-1:0]   w_pp_ext;
    logic signed [ACC_WIDTH-1:0]   w_acc_base;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;

    // Multiplier bit consumed this step: MSB first, so index runs down as cnt runs up.
    assign w_bit_idx   = CNT_W'(WIDTH - 1) - r_cnt;
    assign w_a_bit     = r_a[w_bit_idx];
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_b_ext     = {{WIDTH{r_b[WIDTH-1]}}, r_b};

    // Partial-product addend: the MSB step subtracts b since a's top bit weighs -2^(W-1).
    always_comb begin
        w_addend = '0;
        if (w_a_bit) begin
            w_addend = (r_cnt == '0) ? -w_b_ext : w_b_ext;
        end
    end

    assign w_pp_next  = (r_pp <<< 1) + w_addend;
    // A 2W-bit product always fits, so sign-extension into the accumulator is exact.
    assign w_pp_ext   = ACC_WIDTH'(r_pp);
    assign w_acc_base = r_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + w_pp_ext;

    // Transaction sequencer: accept, serial multiply, accumulate, then hold the output until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_pp        <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_first    <= in_first;
                        r_last     <= in_last;
                        r_pp       <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_pp <= w_pp_next;
                    if (w_last_step) begin
                        r_state <= ACC;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ACC: begin
                    r_acc <= w_acc_next;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;

endmodule
